// File: rtl/alu_reservation_station.sv
// Reservation station for the ALU: holds dispatched ops until both operands are
// known, snoops the CDB for missing operands, and issues one ready op per cycle.
module alu_reservation_station #(
    parameter int ENTRIES = 8,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 32,
    parameter int OP_W    = 6
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear_in,
    input  logic              dsp_valid,
    input  logic [OP_W-1:0]   dsp_op,
    input  logic [DATA_W-1:0] dsp_vj,
    input  logic [DATA_W-1:0] dsp_vk,
    input  logic [TAG_W-1:0]  dsp_qj,
    input  logic [TAG_W-1:0]  dsp_qk,
    input  logic [DATA_W-1:0] dsp_imm,
    input  logic [DATA_W-1:0] dsp_pc,
    input  logic [TAG_W-1:0]  dsp_des_rob,
    output logic              full,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              alu_enable,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_reg1,
    output logic [DATA_W-1:0] alu_reg2,
    output logic [DATA_W-1:0] alu_imm,
    output logic [DATA_W-1:0] alu_pc,
    output logic [TAG_W-1:0]  alu_des_rob
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] busy;
    logic [OP_W-1:0]    op_q      [ENTRIES];
    logic [DATA_W-1:0]  vj_q      [ENTRIES];
    logic [DATA_W-1:0]  vk_q      [ENTRIES];
    logic [TAG_W-1:0]   qj_q      [ENTRIES];
    logic [TAG_W-1:0]   qk_q      [ENTRIES];
    logic [DATA_W-1:0]  imm_q     [ENTRIES];
    logic [DATA_W-1:0]  pc_q      [ENTRIES];
    logic [TAG_W-1:0]   des_rob_q [ENTRIES];

    logic             issue_found;
    logic [IDX_W-1:0] issue_idx;
    logic [IDX_W-1:0] free_idx;
    logic             cdb_hit;

    assign full    = &busy;
    // Tag 0 means "no dependency", so a broadcast on tag 0 must never wake anything.
    assign cdb_hit = cdb_valid && (cdb_tag != '0);

    // Descending scan so the lowest index wins for both issue and allocation.
    always_comb begin
        issue_found = 1'b0;
        issue_idx   = '0;
        free_idx    = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (busy[i] && qj_q[i] == '0 && qk_q[i] == '0) begin
                issue_found = 1'b1;
                issue_idx   = IDX_W'(i);
            end
            if (!busy[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy        <= '0;
            alu_enable  <= 1'b0;
            alu_op      <= '0;
            alu_reg1    <= '0;
            alu_reg2    <= '0;
            alu_imm     <= '0;
            alu_pc      <= '0;
            alu_des_rob <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                op_q[i]      <= '0;
                vj_q[i]      <= '0;
                vk_q[i]      <= '0;
                qj_q[i]      <= '0;
                qk_q[i]      <= '0;
                imm_q[i]     <= '0;
                pc_q[i]      <= '0;
                des_rob_q[i] <= '0;
            end
        end else if (!rdy_in) begin
            alu_enable <= 1'b0;
        end else if (clear_in) begin
            busy        <= '0;
            alu_enable  <= 1'b0;
            alu_op      <= '0;
            alu_reg1    <= '0;
            alu_reg2    <= '0;
            alu_imm     <= '0;
            alu_pc      <= '0;
            alu_des_rob <= '0;
        end else begin
            alu_enable  <= issue_found;
            alu_op      <= issue_found ? op_q[issue_idx]      : '0;
            alu_reg1    <= issue_found ? vj_q[issue_idx]      : '0;
            alu_reg2    <= issue_found ? vk_q[issue_idx]      : '0;
            alu_imm     <= issue_found ? imm_q[issue_idx]     : '0;
            alu_pc      <= issue_found ? pc_q[issue_idx]      : '0;
            alu_des_rob <= issue_found ? des_rob_q[issue_idx] : '0;
            if (issue_found) begin
                busy[issue_idx] <= 1'b0;
            end

            for (int i = 0; i < ENTRIES; i++) begin
                if (busy[i] && cdb_hit && qj_q[i] == cdb_tag) begin
                    vj_q[i] <= cdb_data;
                    qj_q[i] <= '0;
                end
                if (busy[i] && cdb_hit && qk_q[i] == cdb_tag) begin
                    vk_q[i] <= cdb_data;
                    qk_q[i] <= '0;
                end
            end

            // Allocation uses the registered busy vector, so a slot issued this cycle stays unavailable.
            if (dsp_valid && !full) begin
                busy[free_idx]      <= 1'b1;
                op_q[free_idx]      <= dsp_op;
                imm_q[free_idx]     <= dsp_imm;
                pc_q[free_idx]      <= dsp_pc;
                des_rob_q[free_idx] <= dsp_des_rob;
                vj_q[free_idx]      <= (cdb_hit && dsp_qj == cdb_tag) ? cdb_data : dsp_vj;
                qj_q[free_idx]      <= (cdb_hit && dsp_qj == cdb_tag) ? '0 : dsp_qj;
                vk_q[free_idx]      <= (cdb_hit && dsp_qk == cdb_tag) ? cdb_data : dsp_vk;
                qk_q[free_idx]      <= (cdb_hit && dsp_qk == cdb_tag) ? '0 : dsp_qk;
            end
        end
    end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: expected issues are queued at
// dispatch time and popped when alu_enable is expected.
module tb_alu_reservation_station;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_in;
    logic        dsp_valid;
    logic [5:0]  dsp_op;
    logic [31:0] dsp_vj, dsp_vk, dsp_imm, dsp_pc;
    logic [3:0]  dsp_qj, dsp_qk, dsp_des_rob;
    logic        full;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        alu_enable;
    logic [5:0]  alu_op;
    logic [31:0] alu_reg1, alu_reg2, alu_imm, alu_pc;
    logic [3:0]  alu_des_rob;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  des;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    alu_reservation_station #(
        .ENTRIES(8), .TAG_W(4), .DATA_W(32), .OP_W(6)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .dsp_valid(dsp_valid), .dsp_op(dsp_op), .dsp_vj(dsp_vj), .dsp_vk(dsp_vk),
        .dsp_qj(dsp_qj), .dsp_qk(dsp_qk), .dsp_imm(dsp_imm), .dsp_pc(dsp_pc),
        .dsp_des_rob(dsp_des_rob), .full(full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .alu_enable(alu_enable), .alu_op(alu_op), .alu_reg1(alu_reg1),
        .alu_reg2(alu_reg2), .alu_imm(alu_imm), .alu_pc(alu_pc),
        .alu_des_rob(alu_des_rob)
    );

    always #5 clk_in = ~clk_in;

    task automatic cmp(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic apply_stimulus(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                                  input logic [3:0] qj, input logic [3:0] qk,
                                  input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] des);
        dsp_valid   = 1'b1;
        dsp_op      = op;
        dsp_vj      = vj;
        dsp_vk      = vk;
        dsp_qj      = qj;
        dsp_qk      = qk;
        dsp_imm     = imm;
        dsp_pc      = pc;
        dsp_des_rob = des;
    endtask

    task automatic push_exp(input logic [5:0] op, input logic [31:0] r1, input logic [31:0] r2,
                            input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] des);
        exp_t e;
        e.op = op; e.reg1 = r1; e.reg2 = r2; e.imm = imm; e.pc = pc; e.des = des;
        sb.push_back(e);
    endtask

    task automatic check_output(input logic exp_en, input string tag);
        exp_t e;
        cmp({tag, ".enable"}, {31'd0, alu_enable}, {31'd0, exp_en});
        if (exp_en) begin
            if (sb.size() == 0) begin
                miscompares++;
                $error("[TB] FAIL %s.scoreboard observed=empty expected=entry", tag);
            end else begin
                e = sb.pop_front();
                cmp({tag, ".op"},   {26'd0, alu_op},      {26'd0, e.op});
                cmp({tag, ".reg1"}, alu_reg1,             e.reg1);
                cmp({tag, ".reg2"}, alu_reg2,             e.reg2);
                cmp({tag, ".imm"},  alu_imm,              e.imm);
                cmp({tag, ".pc"},   alu_pc,               e.pc);
                cmp({tag, ".des"},  {28'd0, alu_des_rob}, {28'd0, e.des});
            end
        end
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
        dsp_valid = 1'b0; dsp_op = '0; dsp_vj = '0; dsp_vk = '0; dsp_qj = '0; dsp_qk = '0;
        dsp_imm = '0; dsp_pc = '0; dsp_des_rob = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        tick(); tick();
        rst_in = 1'b1;
        cmp("reset.enable", {31'd0, alu_enable}, 32'd0);
        cmp("reset.full",   {31'd0, full},       32'd0);
        cmp("reset.reg1",   alu_reg1,            32'd0);

        // Independent ADD
        apply_stimulus(6'h01, 32'd5, 32'd7, 4'd0, 4'd0, 32'h10, 32'h100, 4'd3);
        push_exp(6'h01, 32'd5, 32'd7, 32'h10, 32'h100, 4'd3);
        tick(); dsp_valid = 1'b0;
        check_output(1'b0, "add.e0");
        tick(); check_output(1'b1, "add.e1");
        tick(); check_output(1'b0, "add.e2");
        cmp("add.idle_reg1", alu_reg1, 32'd0);

        // Dependency wake-up two cycles after dispatch
        apply_stimulus(6'h02, 32'd0, 32'd1, 4'd2, 4'd0, 32'h20, 32'h104, 4'd4);
        tick(); dsp_valid = 1'b0;
        check_output(1'b0, "dep.e0");
        tick(); check_output(1'b0, "dep.e1");
        cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 32'd9;
        push_exp(6'h02, 32'd9, 32'd1, 32'h20, 32'h104, 4'd4);
        tick(); cdb_valid = 1'b0;
        check_output(1'b0, "dep.cdb");
        tick(); check_output(1'b1, "dep.issue");
        tick(); check_output(1'b0, "dep.after");

        // Dispatch and matching broadcast in the same cycle
        apply_stimulus(6'h03, 32'd0, 32'd1, 4'd5, 4'd0, 32'h30, 32'h108, 4'd6);
        cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_data = 32'd9;
        push_exp(6'h03, 32'd9, 32'd1, 32'h30, 32'h108, 4'd6);
        tick(); dsp_valid = 1'b0; cdb_valid = 1'b0;
        check_output(1'b0, "same.e0");
        tick(); check_output(1'b1, "same.issue");
        tick(); check_output(1'b0, "same.after");

        // Broadcast on tag 0 must not disturb a slot with qj==0
        apply_stimulus(6'h04, 32'h11, 32'd0, 4'd0, 4'd7, 32'h40, 32'h10c, 4'd5);
        tick(); dsp_valid = 1'b0;
        check_output(1'b0, "tag0.e0");
        cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_data = 32'hdead;
        tick(); check_output(1'b0, "tag0.bcast");
        cdb_tag = 4'd7; cdb_data = 32'd3;
        push_exp(6'h04, 32'h11, 32'd3, 32'h40, 32'h10c, 4'd5);
        tick(); cdb_valid = 1'b0;
        check_output(1'b0, "tag0.wake");
        tick(); check_output(1'b1, "tag0.issue");

        // Fill all slots behind tag 6, then drop a ninth request
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(6'h05, 32'd0, 32'(i), 4'd6, 4'd0, 32'(i + 100), 32'(i * 4), 4'(i + 1));
            tick();
            check_output(1'b0, "fill.disp");
        end
        cmp("fill.full", {31'd0, full}, 32'd1);
        apply_stimulus(6'h06, 32'd0, 32'd99, 4'd6, 4'd0, 32'd0, 32'd0, 4'd15);
        tick(); dsp_valid = 1'b0;
        cmp("fill.full_drop", {31'd0, full}, 32'd1);
        cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_data = 32'h66;
        for (int i = 0; i < 8; i++) begin
            push_exp(6'h05, 32'h66, 32'(i), 32'(i + 100), 32'(i * 4), 4'(i + 1));
        end
        tick(); cdb_valid = 1'b0;
        check_output(1'b0, "fill.wake");
        for (int i = 0; i < 8; i++) begin
            tick();
            check_output(1'b1, "fill.issue");
            if (i == 0) begin
                cmp("fill.full_release", {31'd0, full}, 32'd0);
            end
        end
        tick(); check_output(1'b0, "fill.dropped");

        // Flush four pending slots
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(6'h07, 32'd0, 32'd0, 4'd9, 4'd0, 32'd0, 32'd0, 4'(i + 1));
            tick();
        end
        dsp_valid = 1'b0;
        clear_in = 1'b1;
        tick(); clear_in = 1'b0;
        check_output(1'b0, "flush.clear");
        cmp("flush.full", {31'd0, full}, 32'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 32'd1;
        tick(); cdb_valid = 1'b0;
        check_output(1'b0, "flush.stale0");
        tick(); check_output(1'b0, "flush.stale1");
        apply_stimulus(6'h08, 32'd21, 32'd22, 4'd0, 4'd0, 32'h50, 32'h200, 4'd8);
        push_exp(6'h08, 32'd21, 32'd22, 32'h50, 32'h200, 4'd8);
        tick(); dsp_valid = 1'b0;
        check_output(1'b0, "flush.new0");
        tick(); check_output(1'b1, "flush.new_issue");

        // Pause with a ready entry and a dependent entry
        apply_stimulus(6'h09, 32'd0, 32'd2, 4'd10, 4'd0, 32'h60, 32'h300, 4'd12);
        tick();
        check_output(1'b0, "pause.dispB");
        apply_stimulus(6'h0a, 32'd31, 32'd32, 4'd0, 4'd0, 32'h70, 32'h304, 4'd13);
        tick(); dsp_valid = 1'b0;
        check_output(1'b0, "pause.dispA");
        rdy_in = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 4'd10; cdb_data = 32'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output(1'b0, "pause.hold");
        end
        rdy_in = 1'b1; cdb_valid = 1'b0;
        push_exp(6'h0a, 32'd31, 32'd32, 32'h70, 32'h304, 4'd13);
        tick(); check_output(1'b1, "pause.resumeA");
        tick(); check_output(1'b0, "pause.B_not_woken");
        cdb_valid = 1'b1; cdb_tag = 4'd10; cdb_data = 32'h77;
        push_exp(6'h09, 32'h77, 32'd2, 32'h60, 32'h300, 4'd12);
        tick(); cdb_valid = 1'b0;
        check_output(1'b0, "pause.wakeB");
        tick(); check_output(1'b1, "pause.issueB");

        // Asynchronous reset mid-operation
        apply_stimulus(6'h0b, 32'd0, 32'd0, 4'd11, 4'd0, 32'd0, 32'd0, 4'd1);
        tick();
        apply_stimulus(6'h0b, 32'd0, 32'd0, 4'd11, 4'd0, 32'd0, 32'd0, 4'd2);
        tick();
        apply_stimulus(6'h0c, 32'd41, 32'd42, 4'd0, 4'd0, 32'h80, 32'h400, 4'd3);
        push_exp(6'h0c, 32'd41, 32'd42, 32'h80, 32'h400, 4'd3);
        tick(); dsp_valid = 1'b0;
        check_output(1'b0, "rst.disp");
        tick(); check_output(1'b1, "rst.inflight");
        #2 rst_in = 1'b0;
        #1;
        cmp("rst.async_enable", {31'd0, alu_enable}, 32'd0);
        cmp("rst.async_full",   {31'd0, full},       32'd0);
        cmp("rst.async_reg1",   alu_reg1,            32'd0);
        tick();
        rst_in = 1'b1;
        cdb_valid = 1'b1; cdb_tag = 4'd11; cdb_data = 32'd5;
        tick(); cdb_valid = 1'b0;
        check_output(1'b0, "rst.post0");
        tick(); check_output(1'b0, "rst.post1");
        cmp("end.scoreboard_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_reservation_station.md
# alu_reservation_station

Buffers dispatched ALU instructions until both source operands are available, captures operands broadcast on the CDB, and issues at most one ready instruction per cycle to the combinational ALU. It sits between the dispatcher/ROB rename stage and the ALU; the ALU's CDB output feeds back into this block's wake-up port.

## Interface
Parameters:
- ENTRIES, 8, number of buffer slots (power of two, ≥2)
- TAG_W, 4, ROB tag width; tag value 0 means "no dependency"
- DATA_W, 32, operand/data width
- OP_W, 6, opcode width (cpu_define op encoding)

Ports:
- clk_in  in  1  clock, all state updates on rising edge
- rst_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global pause; low freezes all state
- clear_in  in  1  synchronous flush (branch mispredict)
- dsp_valid  in  1  dispatch request
- dsp_op  in  OP_W  operation
- dsp_vj, dsp_vk  in  DATA_W  source values
- dsp_qj, dsp_qk  in  TAG_W  source ROB tags; 0 = value already valid
- dsp_imm  in  DATA_W  immediate
- dsp_pc  in  DATA_W  instruction PC
- dsp_des_rob  in  TAG_W  destination ROB tag
- full  out  1  all slots busy
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcast ROB tag
- cdb_data  in  DATA_W  broadcast value
- alu_enable  out  1  issue valid to ALU
- alu_op  out  OP_W; alu_reg1, alu_reg2, alu_imm, alu_pc  out  DATA_W; alu_des_rob  out  TAG_W — issued operands, registered

## Operation
- Per slot state: busy, op, vj, vk, qj, qk, imm, pc, des_rob. Slot ready = busy && qj==0 && qk==0.
- full = all busy bits set (combinational from registered busy vector; no credit for same-cycle issue).
- Each cycle with rdy_in=1 and clear_in=0, in parallel:
  - Issue: lowest-index ready slot (evaluated on registered state) is copied to alu_* outputs, alu_enable=1, slot busy cleared. No ready slot → alu_enable=0, alu_* hold 0.
  - Wake-up: if cdb_valid, every busy slot with qj==cdb_tag gets vj=cdb_data, qj=0; same for qk/vk. Woken slot eligible for issue next cycle.
  - Dispatch: if dsp_valid && !full, write lowest-index non-busy slot. If cdb_valid and dsp_qj==cdb_tag (nonzero), store vj=cdb_data, qj=0 (same for k). dsp_valid while full: request dropped, no state change.
  - Slot freed by issue this cycle is not reusable by dispatch this cycle.
- clear_in=1 (with rdy_in=1): all busy cleared, alu_enable=0 next cycle; same-cycle dispatch and wake-up ignored.
- rdy_in=0: no state changes, alu_enable forced 0 next edge, CDB and dispatch ignored; alu_* data outputs hold.
- cdb_tag==0 never matches.

## Timing
- Reset (rst_in=0, any time, async): all busy=0, full=0, alu_enable=0, all alu_* = 0; in-flight issue discarded.
- Dispatch with qj=qk=0 at edge N → earliest alu_enable=1 after edge N+1 (one cycle in buffer).
- CDB broadcast at edge N resolving last operand → issue after edge N+1.
- alu_enable is a one-cycle pulse per issued instruction; back-to-back issue of different slots on consecutive cycles allowed.
- Throughput: 1 dispatch + 1 issue per cycle.

## Test plan
- Reset mid-operation: fill 3 slots, drop rst_in between edges → alu_enable=0, full=0 immediately; no issue after release.
- Independent ADD: dispatch op=ADD, vj=5, vk=7, qj=qk=0, des_rob=3 at edge 0 → after edge 1 alu_enable=1, alu_reg1=5, alu_reg2=7, alu_des_rob=3; after edge 2 alu_enable=0.
- Dependency wake-up: dispatch qj=2, vk=1; CDB tag=2 data=9 two cycles later → issue next cycle with alu_reg1=9, alu_reg2=1; same-cycle dispatch+CDB tag match also captures 9.
- Full/backpressure: dispatch 8 entries all with qj=6 → full=1; 9th dispatch dropped; CDB tag=6 → issues in slot order 0..7 on 8 consecutive cycles, full deasserts after first issue.
- Flush: 4 busy slots, clear_in pulse → no alu_enable thereafter, full=0, new dispatch issues normally.
- Pause: ready entry present, rdy_in=0 for 3 cycles → alu_enable=0, CDB ignored; rdy_in=1 → issue next cycle.
